// File: rtl/conf_store_if.sv
// Menu <-> configuration store link: indexed read plus BCD write strobe.
interface conf_store_if;
  logic [2:0]  conf_selected_index;
  logic [23:0] conf_selected_value;
  logic [23:0] conf_selected_new_value;
  logic        conf_selected_set;

  modport master (
    output conf_selected_index,
    output conf_selected_new_value,
    output conf_selected_set,
    input  conf_selected_value
  );

  modport slave (
    input  conf_selected_index,
    input  conf_selected_new_value,
    input  conf_selected_set,
    output conf_selected_value
  );
endinterface

// File: rtl/conf_store.sv
// Morse timing register bank: BCD store with a serial
// BCD-to-binary converter feeding the keyer timers.
module conf_store #(
  parameter logic [23:0] DEF_DIT  = 24'h000050,
  parameter logic [23:0] DEF_DAH  = 24'h000150,
  parameter logic [23:0] DEF_WORD = 24'h000350,
  parameter int          BIN_W    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  conf_store_if.slave      cfg,
  output logic [BIN_W-1:0] dit_units,
  output logic [BIN_W-1:0] dah_units,
  output logic [BIN_W-1:0] word_units,
  output logic             conv_busy,
  output logic             conv_done,
  output logic             wr_err
);

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [BIN_W-1:0] bcd2bin(
    input logic [23:0] b
  );
    logic [BIN_W-1:0] a;
    a = '0;
    for (int i = 5; i >= 0; i--)
      a = (a << 3) + (a << 1)
        + BIN_W'(b[i*4 +: 4]);
    return (a == '0) ? BIN_W'(1) : a;
  endfunction

  localparam logic [BIN_W-1:0] DIT_BIN  = bcd2bin(DEF_DIT);
  localparam logic [BIN_W-1:0] DAH_BIN  = bcd2bin(DEF_DAH);
  localparam logic [BIN_W-1:0] WORD_BIN = bcd2bin(DEF_WORD);

  state_t           r_state;
  logic [23:0]      r_store [3];
  logic [BIN_W-1:0] r_bin   [3];
  logic [2:0]       r_pend;
  logic [1:0]       r_sel;
  logic [23:0]      r_shift;
  logic [BIN_W-1:0] r_acc;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_idx_ok;
  logic             w_bcd_ok;
  logic             w_wr;
  logic [1:0]       w_pick;
  logic [2:0]       w_pend_nxt;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] w_acc_nxt;
  logic [BIN_W-1:0] w_final;

  assign w_idx_ok = cfg.conf_selected_index < 3'd3;

  always_comb begin
    w_bcd_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (cfg.conf_selected_new_value[i*4 +: 4] > 4'd9)
        w_bcd_ok = 1'b0;
  end

  assign w_wr = cfg.conf_selected_set & w_idx_ok & w_bcd_ok;

  always_comb begin
    w_pick = 2'd0;
    unique case (1'b1)
      r_pend[0]: w_pick = 2'd0;
      r_pend[1]: w_pick = 2'd1;
      r_pend[2]: w_pick = 2'd2;
      default:   w_pick = 2'd0;
    endcase
  end

  // A write in the same edge as the pick keeps the bit set
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == IDLE && r_pend != 3'b000)
      w_pend_nxt[w_pick] = 1'b0;
    if (w_wr)
      w_pend_nxt[cfg.conf_selected_index[1:0]] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (r_pend != 3'b000) w_state_nxt = CONV;
      CONV: if (r_cnt == 3'd5)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc_nxt = (r_acc << 3) + (r_acc << 1)
                   + BIN_W'(r_shift[23:20]);
  assign w_final   = (w_acc_nxt == '0) ? BIN_W'(1)
                                       : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_store[0] <= DEF_DIT;
      r_store[1] <= DEF_DAH;
      r_store[2] <= DEF_WORD;
      r_bin[0]   <= DIT_BIN;
      r_bin[1]   <= DAH_BIN;
      r_bin[2]   <= WORD_BIN;
      r_pend     <= 3'b000;
      r_sel      <= 2'd0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (ce) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE)
               | (w_pend_nxt != 3'b000);
      if (cfg.conf_selected_set && w_idx_ok) begin
        if (w_bcd_ok)
          r_store[cfg.conf_selected_index[1:0]]
            <= cfg.conf_selected_new_value;
        else
          r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: if (r_pend != 3'b000) begin
          r_sel   <= w_pick;
          r_shift <= r_store[w_pick];
          r_acc   <= '0;
          r_cnt   <= 3'd0;
        end
        CONV: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << 4;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd5) begin
            r_bin[r_sel] <= w_final;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg.conf_selected_value =
    w_idx_ok ? r_store[cfg.conf_selected_index[1:0]]
             : 24'h000000;

  assign dit_units  = r_bin[0];
  assign dah_units  = r_bin[1];
  assign word_units = r_bin[2];
  assign conv_busy  = r_busy;
  assign conv_done  = r_done;
  assign wr_err     = r_err;

endmodule
